// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Arbiter FSM encoding: IDLE arbitrates, GRANT holds one requester.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, mod 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // Rotate requests so bit 0 is the highest-priority requester.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SEL_W-1:0]     offset;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  // Lowest set bit of the rotated vector is the winner's distance from ptr.
  always_comb begin
    // NOTE: defaulting every output first keeps always_comb from inferring a latch.
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SEL_W'(k);
    end
  end

  assign found = |req;
  assign idx   = ptr + offset;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select and handshakes of a shared mux4.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] in_valid,
  input  logic [NUM_REQ-1:0] in_last,
  output logic [NUM_REQ-1:0] in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [CNT_W-1:0]   beat_cnt
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             granted;
  logic             xfer;
  logic             release_now;

  rr_pick4 u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Handshake decode depends only on registered state/sel and live inputs;
  // out_valid never looks at out_ready.
  assign granted     = (state_q == ST_GRANT);
  assign out_valid   = granted && in_valid[sel_q];
  assign in_ready    = (granted && out_ready) ? (NUM_REQ'(1) << sel_q) : '0;
  assign xfer        = out_valid && out_ready;
  assign release_now = in_last[sel_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          sel_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          if (release_now) begin
            state_d    = ST_IDLE;
            ptr_d      = sel_q + SEL_W'(1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, select, pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = granted;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: a behavioural model predicts per-cycle outputs and every
// accepted beat; a negedge monitor compares them against the DUT.
module tb_mux4_rr_arbiter;

  localparam int MAXB  = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       in_valid = '0;
  logic [3:0]       in_last = '0;
  logic [3:0]       in_ready;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [1:0]       sel;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;

  mux4_rr_arbiter #(.MAX_BURST(MAXB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       busy;
    bit [1:0] sel;
    bit       ov;
    bit [3:0] ir;
    int       bc;
  } cyc_exp_t;

  typedef struct {
    int req;
    int beat;
  } beat_exp_t;

  cyc_exp_t  cyc_q[$];
  beat_exp_t beat_q[$];
  int        obs_sel[$];
  int        obs_beat[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: who owns the mux (-1 = nobody), priority pointer, beats so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_sel   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Predict this cycle's outputs from the current inputs, then advance the model.
  task automatic model_cycle();
    cyc_exp_t  e;
    beat_exp_t b;
    bit        xfer;
    int        winner;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0;
    end
    e.busy = (m_owner >= 0);
    e.sel  = 2'(m_sel);
    e.ov   = (m_owner >= 0) ? in_valid[m_owner] : 1'b0;
    e.ir   = (e.busy && out_ready) ? 4'(1 << m_owner) : 4'b0;
    e.bc   = m_beats;
    cyc_q.push_back(e);
    xfer = e.ov && out_ready;
    if (rst_n) begin
      if (m_owner < 0) begin
        winner = -1;
        for (int k = 0; k < 4; k++)
          if (winner < 0 && in_valid[(m_ptr + k) % 4]) winner = (m_ptr + k) % 4;
        if (winner >= 0) begin
          m_owner = winner; m_sel = winner; m_beats = 0;
        end
      end else if (xfer) begin
        b.req = m_owner; b.beat = m_beats;
        beat_q.push_back(b);
        m_beats++;
        if (in_last[m_owner] || m_beats == MAXB) begin
          m_ptr = (m_owner + 1) % 4; m_owner = -1; m_beats = 0;
        end
      end
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] v, input logic [3:0] l, input logic ordy);
    @(posedge clk); #1;
    rst_n = rn; in_valid = v; in_last = l; out_ready = ordy;
    model_cycle();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b1111, 4'b0000, 1'b1);
  endtask

  task automatic clear_log();
    obs_sel.delete(); obs_beat.delete();
  endtask

  // Monitor: compares outputs every cycle and each accepted beat.
  initial begin : monitor
    cyc_exp_t  e;
    beat_exp_t b;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("busy",      32'(busy),      32'(e.busy));
        check("sel",       32'(sel),       32'(e.sel));
        check("out_valid", 32'(out_valid), 32'(e.ov));
        check("in_ready",  32'(in_ready),  32'(e.ir));
        check("beat_cnt",  32'(beat_cnt),  32'(e.bc));
      end
      if (out_valid && out_ready) begin
        obs_sel.push_back(int'(sel));
        obs_beat.push_back(int'(beat_cnt));
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = beat_q.pop_front();
          check("beat_req", 32'(sel),      32'(b.req));
          check("beat_idx", 32'(beat_cnt), 32'(b.beat));
        end
      end
    end
  end

  initial begin : driver
    int fair_order[5];
    int forced_beats[8];
    fair_order   = '{0, 1, 2, 3, 0};
    forced_beats = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset held with every requester valid, then fairness with 1-beat bursts.
    do_reset(3);
    clear_log();
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    check("fair_count", 32'(obs_sel.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < obs_sel.size()) check("fair_order", 32'(obs_sel[i]), 32'(fair_order[i]));

    // Forced release: requester 2 streams without last.
    do_reset(1);
    clear_log();
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    check("forced_count", 32'(obs_beat.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < obs_beat.size()) begin
        check("forced_beat", 32'(obs_beat[i]), 32'(forced_beats[i]));
        check("forced_sel",  32'(obs_sel[i]),  32'd2);
      end
    // Requesters 2 and 3 both valid: after 2 is forced off, 3 wins.
    for (int i = 0; i < 12; i++) step(1'b1, 4'b1100, 4'b0000, 1'b1);

    // Backpressure on requester 1.
    do_reset(1);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    step(1'b1, 4'b0010, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0011, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 4'b0010, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b1);

    // Valid gap mid-burst on requester 0, completed by last.
    step(1'b1, 4'b0001, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 4'b0001, 1'b1);
    step(1'b1, 4'b0001, 4'b0001, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b1);

    // Async reset at beat 2 of a burst, then recovery.
    step(1'b1, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b1000, 4'b0000, 1'b1);
    step(1'b0, 4'b1000, 4'b0000, 1'b1);
    step(1'b1, 4'b1000, 4'b1000, 1'b1);
    step(1'b1, 4'b1000, 4'b1000, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      logic [3:0] l;
      for (int b = 0; b < 4; b++) begin
        v[b] = ($urandom_range(0, 9) < 6);
        l[b] = ($urandom_range(0, 3) == 0);
      end
      step(($urandom_range(0, 299) != 0), v, l, ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("cyc_q_drained",  32'(cyc_q.size()),  32'd0);
    check("beat_q_drained", 32'(beat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
